// File: rtl/register_dump_sender.sv
// Streams a snapshot of the register file out through a UART TX byte interface:
// registers in ascending index order, four bytes each, most significant byte first.
module register_dump_sender #(
  parameter int NUM_REGS    = 32,
  parameter int INDEX_WIDTH = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [31:0]            register_value,
  input  logic                   tx_done,
  output logic [INDEX_WIDTH-1:0] register_index,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  output logic                   busy,
  output logic                   dump_done
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] SEND   = 3'd2;
  localparam logic [2:0] WAIT   = 3'd3;
  localparam logic [2:0] FINISH = 3'd4;

  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(NUM_REGS - 1);

  logic [2:0]  state;
  logic [1:0]  byte_count;
  logic [31:0] shift;

  // All outputs are registered; tx_start and dump_done default low so they
  // only ever pulse for a single cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      register_index <= '0;
      tx_data        <= '0;
      tx_start       <= 1'b0;
      busy           <= 1'b0;
      dump_done      <= 1'b0;
      byte_count     <= '0;
      shift          <= '0;
    end else begin
      // NOTE: non-blocking assignments make every branch see the pre-edge
      // values of state, shift and byte_count, as real flip-flops would.
      tx_start  <= 1'b0;
      dump_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            register_index <= '0;
            busy           <= 1'b1;
            state          <= FETCH;
          end
        end
        FETCH: begin
          // The index was updated on the previous edge, so the mux has settled.
          shift      <= register_value;
          byte_count <= '0;
          state      <= SEND;
        end
        SEND: begin
          tx_start <= 1'b1;
          tx_data  <= shift[31:24];
          state    <= WAIT;
        end
        WAIT: begin
          if (tx_done) begin
            if (byte_count != 2'd3) begin
              shift      <= {shift[23:0], 8'h00};
              byte_count <= byte_count + 2'd1;
              state      <= SEND;
            end else if (register_index < LAST_INDEX) begin
              register_index <= register_index + INDEX_WIDTH'(1);
              state          <= FETCH;
            end else begin
              dump_done <= 1'b1;
              state     <= FINISH;
            end
          end
        end
        FINISH: begin
          busy           <= 1'b0;
          register_index <= '0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_register_dump_sender.sv
// Directed bench for register_dump_sender: a register-file mux and a UART model
// that answers each tx_start with tx_done a fixed number of cycles later.
module tb_register_dump_sender;

  localparam int NUM_REGS    = 32;
  localparam int INDEX_WIDTH = 5;
  localparam int NUM_BYTES   = 4 * NUM_REGS;
  localparam int DELAY       = 10;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   start;
  logic [31:0]            register_value;
  logic                   tx_done;
  logic [INDEX_WIDTH-1:0] register_index;
  logic [7:0]             tx_data;
  logic                   tx_start;
  logic                   busy;
  logic                   dump_done;

  register_dump_sender #(.NUM_REGS(NUM_REGS), .INDEX_WIDTH(INDEX_WIDTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .register_value (register_value),
    .tx_done        (tx_done),
    .register_index (register_index),
    .tx_data        (tx_data),
    .tx_start       (tx_start),
    .busy           (busy),
    .dump_done      (dump_done)
  );

  always #5 clock = ~clock;

  logic [31:0] regs [NUM_REGS];
  assign register_value = regs[register_index];

  // UART model and spurious-pulse sources
  int   cnt = 0;
  logic uart_done = 1'b0;
  logic spur_q = 1'b0;
  logic stall, spur_send, spur_idle;
  assign tx_done = uart_done | spur_q | spur_idle;

  always @(negedge clock) begin
    if (!reset) begin
      cnt       <= 0;
      uart_done <= 1'b0;
      spur_q    <= 1'b0;
    end else begin
      uart_done <= !stall && !tx_start && (cnt == 1);
      spur_q    <= spur_send && uart_done;
      if (tx_start)                cnt <= DELAY;
      else if (!stall && cnt != 0) cnt <= cnt - 1;
    end
  end

  // Monitor: cycle stamps are the index of the rising edge just before sampling.
  int          cyc = 0;
  logic [7:0]  bytes [$];
  int          t_start [$];
  int          t_done [$];
  int          done_count = 0;
  int          done_cyc = 0;
  logic        busy_at_done = 1'b0;
  logic        busy_after = 1'b1;
  logic        after_pending = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (tx_start) begin
      bytes.push_back(tx_data);
      t_start.push_back(cyc);
    end
    if (uart_done) t_done.push_back(cyc);
    if (dump_done) begin
      done_count    <= done_count + 1;
      done_cyc      <= cyc;
      busy_at_done  <= busy;
      after_pending <= 1'b1;
    end
    if (after_pending) begin
      busy_after    <= busy;
      after_pending <= 1'b0;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  logic [7:0] exp_bytes [NUM_BYTES];

  task automatic build_expected();
    for (int r = 0; r < NUM_REGS; r++)
      for (int b = 0; b < 4; b++)
        exp_bytes[4*r + b] = regs[r][31 - 8*b -: 8];
  endtask

  task automatic clear_mon();
    bytes.delete();
    t_start.delete();
    t_done.delete();
  endtask

  int s_cyc;

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    s_cyc = cyc;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int n = 0;
    while (done_count == d0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("dump_done_within_budget", 64'(done_count != d0), 64'd1);
  endtask

  task automatic wait_bytes(input int target, input int budget);
    int n = 0;
    while (bytes.size() < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("bytes_reached_within_budget", 64'(bytes.size() >= target), 64'd1);
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_byte_count"}, 64'(bytes.size()), 64'(NUM_BYTES));
    for (int i = 0; i < NUM_BYTES && i < bytes.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 64'(bytes[i]), 64'(exp_bytes[i]));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_register_index"}, 64'(register_index), 64'd0);
    check({tag, "_tx_data"},        64'(tx_data),        64'd0);
    check({tag, "_tx_start"},       64'(tx_start),       64'd0);
    check({tag, "_busy"},           64'(busy),           64'd0);
    check({tag, "_dump_done"},      64'(dump_done),      64'd0);
  endtask

  typedef struct {
    int         pos;
    logic [7:0] exp;
  } byte_vec_t;

  byte_vec_t vecs [16];
  int d0;
  int n;

  initial begin
    vecs = '{
      '{0, 8'h00},  '{4, 8'h00},  '{5, 8'h00},  '{6, 8'h00},
      '{7, 8'h0A},  '{15, 8'h0F}, '{20, 8'hFF}, '{21, 8'hFF},
      '{22, 8'hFF}, '{23, 8'hFB}, '{27, 8'h0C}, '{63, 8'h05},
      '{64, 8'hAA}, '{65, 8'hAA}, '{66, 8'hAA}, '{67, 8'hAA}
    };

    reset = 1'b0; start = 1'b0; stall = 1'b0; spur_send = 1'b0; spur_idle = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) regs[r] = '0;
    regs[1]  = 32'd10;
    regs[3]  = 32'd15;
    regs[5]  = 32'hFFFF_FFFB;
    regs[6]  = 32'd12;
    regs[15] = 32'd5;
    regs[16] = 32'hAAAA_AAAA;

    // Reset held while start pulses: nothing may leave the block.
    repeat (2) @(negedge clock);
    start = 1'b1;
    repeat (2) @(negedge clock);
    start = 1'b0;
    check_outputs_zero("in_reset");
    reset = 1'b1;
    @(negedge clock);
    check_outputs_zero("after_reset");
    repeat (100) @(negedge clock);
    check("reset_no_tx_start", 64'(bytes.size()), 64'd0);
    check("reset_idle_busy", 64'(busy), 64'd0);

    // Full dump with latency and gap timing.
    build_expected();
    clear_mon();
    d0 = done_count;
    pulse_start();
    wait_done(d0, 5000);
    repeat (20) @(negedge clock);
    check("full_one_dump_done", 64'(done_count - d0), 64'd1);
    compare_stream("full");
    foreach (vecs[i])
      if (vecs[i].pos < bytes.size())
        check($sformatf("vec_byte%0d", vecs[i].pos), 64'(bytes[vecs[i].pos]), 64'(vecs[i].exp));
    check("tx_done_count", 64'(t_done.size()), 64'(NUM_BYTES));
    if (t_start.size() >= 5 && t_done.size() == NUM_BYTES) begin
      check("start_latency",       64'(t_start[0] - s_cyc),        64'd3);
      check("gap_within_register", 64'(t_start[1] - t_done[0]),    64'd1);
      check("gap_across_register", 64'(t_start[4] - t_done[3]),    64'd2);
      check("done_after_last",     64'(done_cyc - t_done[NUM_BYTES-1]), 64'd0);
    end
    check("busy_during_done", 64'(busy_at_done), 64'd1);
    check("busy_after_done",  64'(busy_after),   64'd0);

    // Spurious tx_done in IDLE, then a dump with spurious tx_done in SEND
    // and start pulses throughout, including the FINISH cycle.
    clear_mon();
    @(negedge clock);
    spur_idle = 1'b1;
    @(negedge clock);
    spur_idle = 1'b0;
    repeat (5) @(negedge clock);
    check("spur_idle_busy",  64'(busy),          64'd0);
    check("spur_idle_bytes", 64'(bytes.size()),  64'd0);
    spur_send = 1'b1;
    d0 = done_count;
    pulse_start();
    n = 0;
    while (!dump_done && n < 5000) begin
      start = ((n % 37) == 5);
      @(negedge clock);
      n++;
    end
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    spur_send = 1'b0;
    repeat (100) @(negedge clock);
    check("ignored_one_dump_done", 64'(done_count - d0), 64'd1);
    check("ignored_busy_after",    64'(busy),            64'd0);
    compare_stream("ignored");

    // Stalled tx_done: output frozen, no extra request.
    clear_mon();
    d0 = done_count;
    pulse_start();
    wait_bytes(24, 2000);
    stall = 1'b1;
    repeat (1000) @(negedge clock);
    check("stall_bytes",    64'(bytes.size()), 64'd24);
    check("stall_tx_data",  64'(tx_data),      64'(exp_bytes[23]));
    check("stall_tx_start", 64'(tx_start),     64'd0);
    check("stall_busy",     64'(busy),         64'd1);
    stall = 1'b0;
    wait_done(d0, 5000);
    repeat (5) @(negedge clock);
    compare_stream("stall");

    // Reset in the middle of a dump, then a fresh dump from register 0.
    clear_mon();
    pulse_start();
    wait_bytes(50, 2000);
    #3 reset = 1'b0;
    #1 check_outputs_zero("midreset");
    repeat (3) @(negedge clock);
    reset = 1'b1;
    clear_mon();
    d0 = done_count;
    pulse_start();
    wait_done(d0, 5000);
    repeat (5) @(negedge clock);
    if (bytes.size() > 0) check("midreset_first_byte", 64'(bytes[0]), 64'(exp_bytes[0]));
    compare_stream("after_midreset");

    // Snapshot: rewriting r2 after its FETCH must not reach the bytes already latched.
    clear_mon();
    d0 = done_count;
    pulse_start();
    wait_bytes(10, 2000);
    regs[2] = 32'h1122_3344;
    wait_done(d0, 5000);
    repeat (5) @(negedge clock);
    for (int i = 8; i < 12; i++)
      if (i < bytes.size()) check($sformatf("snapshot_byte%0d", i), 64'(bytes[i]), 64'h00);
    compare_stream("snapshot");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
